// File: rtl/seg7_factor_monitor.sv
// seg7_factor_monitor
//   Receive side of the 7-segment factor display. The segment lines are
//   registered and debounced. Each newly accepted glyph is decoded to a
//   digit, and the 1..9 digit cycle shown on the display is used to rebuild
//   the 8-bit factor mask.
//
// Ports
//   clk            clock
//   reset          synchronous, active-high reset
//   segments_in    segment lines {g,f,e,d,c,b,a}, bit0 = a
//   clear          sync: FSM to IDLE, mask and sticky errors cleared
//                  (the debounce filter and last_glyph are not touched)
//   digit_out      last accepted digit 0..9
//   digit_valid    1-cycle pulse per accepted valid digit
//   factors_out    bit k set = digit k+2 divides the displayed number
//   factors_valid  1-cycle pulse; factors_out is updated in the same cycle
//   frame_busy     high while collecting a frame
//   glyph_error    sticky: an unrecognised glyph was accepted
//   seq_error      sticky: the digit order was violated
module seg7_factor_monitor #(
   parameter int unsigned STABLE_CYCLES  = 4,
   parameter int unsigned TIMEOUT_CYCLES = 30_000_000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [6:0] segments_in,
   input  logic       clear,
   output logic [3:0] digit_out,
   output logic       digit_valid,
   output logic [7:0] factors_out,
   output logic       factors_valid,
   output logic       frame_busy,
   output logic       glyph_error,
   output logic       seq_error
);

   localparam int unsigned CNT_W = $clog2(STABLE_CYCLES + 1);
   localparam int unsigned TMR_W = $clog2(TIMEOUT_CYCLES);

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);
   localparam logic [TMR_W-1:0] TMR_MAX = TMR_W'(TIMEOUT_CYCLES - 1);

   localparam logic [0:0] ST_IDLE    = 1'b0;
   localparam logic [0:0] ST_COLLECT = 1'b1;

   logic [6:0]       seg_r;
   logic [6:0]       last_glyph;
   logic [CNT_W-1:0] stable_cnt;
   logic             accept;

   logic [3:0]       dec_digit;
   logic             dec_valid;

   logic [0:0]       state;
   logic [7:0]       mask;
   logic [3:0]       last_d;
   logic [TMR_W-1:0] timer;

   // ------------------------------------------------------------------
   // Debounce filter. The counter restarts whenever the incoming sample
   // differs from the registered one, and it saturates at CNT_MAX. Once it
   // saturates, the glyph counts as stable. last_glyph then prevents the
   // same glyph from being accepted again, so each change is accepted once.
   // ------------------------------------------------------------------
   assign accept = (stable_cnt == CNT_MAX) && (seg_r != last_glyph);

   always_ff @(posedge clk) begin
      if (reset) begin
         seg_r      <= 7'h3F;
         last_glyph <= 7'h3F;
         stable_cnt <= '0;
      end else begin
         seg_r <= segments_in;
         if (segments_in != seg_r)
            stable_cnt <= '0;
         else if (stable_cnt != CNT_MAX)
            stable_cnt <= stable_cnt + 1'b1;
         // last_glyph is updated even when clear masks the event. This keeps
         // the filter independent of the frame logic.
         if (accept)
            last_glyph <= seg_r;
      end
   end

   // ------------------------------------------------------------------
   // Glyph decoder
   // ------------------------------------------------------------------
   always_comb begin
      dec_digit = 4'd0;
      dec_valid = 1'b1;
      case (seg_r)
         7'h3F:   dec_digit = 4'd0;
         7'h06:   dec_digit = 4'd1;
         7'h5B:   dec_digit = 4'd2;
         7'h4F:   dec_digit = 4'd3;
         7'h66:   dec_digit = 4'd4;
         7'h6D:   dec_digit = 4'd5;
         7'h7D:   dec_digit = 4'd6;
         7'h07:   dec_digit = 4'd7;
         7'h7F:   dec_digit = 4'd8;
         7'h6F:   dec_digit = 4'd9;
         default: dec_valid = 1'b0;
      endcase
   end

   // ------------------------------------------------------------------
   // Frame FSM. Priority order: clear, then an accepted event, then the
   // timeout. Every accepted event in COLLECT either restarts the timer or
   // leaves COLLECT, so the timer is restarted on any accept.
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= ST_IDLE;
         mask          <= '0;
         last_d        <= '0;
         timer         <= '0;
         digit_out     <= '0;
         digit_valid   <= 1'b0;
         factors_out   <= '0;
         factors_valid <= 1'b0;
         glyph_error   <= 1'b0;
         seq_error     <= 1'b0;
      end else begin
         digit_valid   <= 1'b0;
         factors_valid <= 1'b0;
         if (clear) begin
            state       <= ST_IDLE;
            mask        <= '0;
            timer       <= '0;
            glyph_error <= 1'b0;
            seq_error   <= 1'b0;
         end else if (accept) begin
            timer <= '0;
            if (!dec_valid) begin
               glyph_error <= 1'b1;
               state       <= ST_IDLE;
               mask        <= '0;
            end else begin
               digit_out   <= dec_digit;
               digit_valid <= 1'b1;
               if (state == ST_IDLE) begin
                  if (dec_digit == 4'd1) begin
                     state  <= ST_COLLECT;
                     mask   <= '0;
                     last_d <= 4'd1;
                  end
               end else begin
                  if (dec_digit == 4'd1) begin
                     // A closing "1" ends the frame and starts the next one.
                     factors_out   <= mask;
                     factors_valid <= 1'b1;
                     mask          <= '0;
                     last_d        <= 4'd1;
                  end else if (dec_digit == 4'd0) begin
                     state <= ST_IDLE;
                     mask  <= '0;
                  end else if (dec_digit > last_d) begin
                     mask   <= mask | (8'd1 << (dec_digit - 4'd2));
                     last_d <= dec_digit;
                  end else begin
                     seq_error <= 1'b1;
                     state     <= ST_IDLE;
                     mask      <= '0;
                  end
               end
            end
         end else if (state == ST_COLLECT) begin
            if (timer == TMR_MAX) begin
               timer <= '0;
               if (last_d == 4'd1) begin
                  // The display keeps showing "1" when the number has no
                  // factor in 2..9, so no glyph change arrives. Report an
                  // empty mask.
                  factors_out   <= '0;
                  factors_valid <= 1'b1;
               end else begin
                  state <= ST_IDLE;
                  mask  <= '0;
               end
            end else begin
               timer <= timer + 1'b1;
            end
         end
      end
   end

   assign frame_busy = (state == ST_COLLECT);

endmodule

// File: tb/tb_seg7_factor_monitor.sv
module tb_seg7_factor_monitor;

   localparam int S = 4;
   localparam int T = 200;

   logic       clk = 1'b0;
   logic       reset;
   logic [6:0] segments_in;
   logic       clear;
   logic [3:0] digit_out;
   logic       digit_valid;
   logic [7:0] factors_out;
   logic       factors_valid;
   logic       frame_busy;
   logic       glyph_error;
   logic       seq_error;

   seg7_factor_monitor #(
      .STABLE_CYCLES (S),
      .TIMEOUT_CYCLES(T)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .segments_in  (segments_in),
      .clear        (clear),
      .digit_out    (digit_out),
      .digit_valid  (digit_valid),
      .factors_out  (factors_out),
      .factors_valid(factors_valid),
      .frame_busy   (frame_busy),
      .glyph_error  (glyph_error),
      .seq_error    (seq_error)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   logic [6:0] glyph_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                  7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

   function automatic int glyph_digit(input logic [6:0] g);
      for (int i = 0; i < 10; i++)
         if (glyph_tab[i] == g) return i;
      return -1;
   endfunction

   // Reference model. It works on edge timestamps: a hold is the run of
   // identical samples that started at hold_start.
   int         edge_n = 0;
   logic [6:0] cur_glyph;
   int         hold_start;
   logic [6:0] m_last_glyph;
   bit         m_busy;
   logic [7:0] m_mask;
   int         m_last_d;
   int         m_base;
   logic [3:0] m_digit;
   logic [7:0] m_fout;
   bit         m_gerr, m_serr;

   // Observation bookkeeping for the directed checks.
   int dv_cnt, fv_cnt, last_dv_edge, fall_edge;
   logic [7:0] last_fout;
   int fv_edges[$];
   bit prev_busy;

   task automatic run_cycle(input logic [6:0] seg, input bit clr);
      bit ev, exp_dv, exp_fv;
      int d, e;
      logic [6:0] g;
      @(negedge clk);
      segments_in = seg;
      clear       = clr;
      @(posedge clk);
      edge_n++;
      e      = edge_n;
      ev     = 0;
      exp_dv = 0;
      exp_fv = 0;
      g      = cur_glyph;
      if ((e - hold_start) == S && cur_glyph != m_last_glyph) begin
         ev = 1;
         m_last_glyph = cur_glyph;
      end
      if (seg != cur_glyph) begin
         cur_glyph  = seg;
         hold_start = e;
      end
      if (clr) begin
         m_busy = 0; m_mask = '0; m_gerr = 0; m_serr = 0;
      end else if (ev) begin
         d = glyph_digit(g);
         if (d < 0) begin
            m_gerr = 1; m_busy = 0; m_mask = '0;
         end else begin
            exp_dv  = 1;
            m_digit = 4'(d);
            if (!m_busy) begin
               if (d == 1) begin
                  m_busy = 1; m_mask = '0; m_last_d = 1; m_base = e;
               end
            end else if (d == 1) begin
               exp_fv = 1; m_fout = m_mask; m_mask = '0; m_last_d = 1; m_base = e;
            end else if (d == 0) begin
               m_busy = 0; m_mask = '0;
            end else if (d > m_last_d) begin
               m_mask[d-2] = 1'b1; m_last_d = d; m_base = e;
            end else begin
               m_serr = 1; m_busy = 0; m_mask = '0;
            end
         end
      end else if (m_busy && (e - m_base) == T) begin
         if (m_last_d == 1) begin
            exp_fv = 1; m_fout = '0; m_base = e;
         end else begin
            m_busy = 0; m_mask = '0;
         end
      end
      #1;
      check("outs",
            {15'd0, digit_out, digit_valid, factors_out, factors_valid, frame_busy, glyph_error, seq_error},
            {15'd0, m_digit, exp_dv, m_fout, exp_fv, m_busy, m_gerr, m_serr});
      if (digit_valid) begin dv_cnt++; last_dv_edge = e; end
      if (factors_valid) begin fv_cnt++; last_fout = factors_out; fv_edges.push_back(e); end
      if (prev_busy && !frame_busy) fall_edge = e;
      prev_busy = frame_busy;
   endtask

   task automatic hold(input logic [6:0] g, input int n);
      for (int i = 0; i < n; i++) run_cycle(g, 1'b0);
   endtask

   task automatic reset_obs();
      dv_cnt = 0; fv_cnt = 0; fall_edge = -1; last_dv_edge = -1;
      last_fout = '0;
      fv_edges.delete();
   endtask

   initial begin
      reset = 1'b1; clear = 1'b0; segments_in = 7'h3F;
      repeat (3) @(posedge clk);
      #1;
      check("reset", {25'd0, digit_out, digit_valid, factors_out[1:0], factors_valid,
                      frame_busy, glyph_error, seq_error}, 32'd0);
      check("reset_fout", {24'd0, factors_out}, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      cur_glyph = 7'h3F; hold_start = edge_n; m_last_glyph = 7'h3F;
      m_busy = 0; m_mask = '0; m_last_d = 0; m_base = 0;
      m_digit = '0; m_fout = '0; m_gerr = 0; m_serr = 0; prev_busy = 0;

      // 1: idle display
      reset_obs();
      hold(7'h3F, 300);
      check("t1_dv", dv_cnt, 0);
      check("t1_fv", fv_cnt, 0);

      // 2: number 12
      reset_obs();
      hold(7'h06, 50); hold(7'h5B, 50); hold(7'h4F, 50);
      hold(7'h66, 50); hold(7'h7D, 50); hold(7'h06, 50);
      check("t2_dv", dv_cnt, 6);
      check("t2_fv", fv_cnt, 1);
      check("t2_mask", {24'd0, last_fout}, 32'h17);
      check("t2_busy", {31'd0, frame_busy}, 1);

      // 3: glitch is filtered
      hold(7'h3F, 50);
      reset_obs();
      hold(7'h06, 50); hold(7'h5B, 3); hold(7'h06, 50);
      check("t3_dv", dv_cnt, 1);

      // 4: invalid glyph, then clear
      hold(7'h3F, 50); hold(7'h06, 50); hold(7'h40, 10);
      check("t4_gerr", {31'd0, glyph_error}, 1);
      check("t4_busy", {31'd0, frame_busy}, 0);
      run_cycle(7'h40, 1'b1);
      check("t4_clr", {31'd0, glyph_error}, 0);

      // 5: order violation
      hold(7'h3F, 50);
      reset_obs();
      hold(7'h06, 50); hold(7'h66, 50); hold(7'h4F, 50);
      check("t5_serr", {31'd0, seq_error}, 1);
      check("t5_busy", {31'd0, frame_busy}, 0);
      check("t5_fv", fv_cnt, 0);

      // 6: timeouts
      hold(7'h3F, 50);
      run_cycle(7'h3F, 1'b1);
      reset_obs();
      hold(7'h06, 500);
      check("t6_nfv", fv_edges.size(), 2);
      if (fv_edges.size() >= 2) begin
         check("t6_fv1", fv_edges[0] - last_dv_edge, 200);
         check("t6_fv2", fv_edges[1] - last_dv_edge, 400);
      end
      hold(7'h3F, 50);
      reset_obs();
      hold(7'h06, 50); hold(7'h6D, 400);
      check("t6_fall", fall_edge - last_dv_edge, 200);
      check("t6_fv0", fv_cnt, 0);
      check("t6_err", {30'd0, glyph_error, seq_error}, 0);

      // random holds against the model
      for (int h = 0; h < 250; h++) begin
         int r, len, clr_at;
         logic [6:0] g;
         r = $urandom_range(99);
         if (r < 30)      g = 7'h06;
         else if (r < 88) g = glyph_tab[$urandom_range(9)];
         else             g = 7'($urandom_range(127));
         len    = ($urandom_range(99) < 8) ? $urandom_range(450, 150) : $urandom_range(40, 1);
         clr_at = ($urandom_range(99) < 4) ? $urandom_range(len - 1) : -1;
         for (int c = 0; c < len; c++) run_cycle(g, c == clr_at);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
